// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl: run-control unit for the pipelined CPU.
// Turns HALT / RUN / STEP N / CPU_RST commands into a registered pipeline
// enable and CPU reset, and counts the cycles in which the core was enabled.
// Optional breakpoint support is compiled in with PIPE_RUN_CTRL_BREAKPOINT_EN.
module pipeline_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int PC_W       = 32,
  parameter int CYC_W      = 32,
  parameter int RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [PC_W-1:0]  pc_in,
`ifdef PIPE_RUN_CTRL_BREAKPOINT_EN
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  output logic             bp_hit,
`endif
  output logic             enable,
  output logic             cpu_rst,
  output logic             busy,
  output logic [CYC_W-1:0] cycle_count
);

  localparam logic [1:0] OP_HALT    = 2'd0;
  localparam logic [1:0] OP_RUN     = 2'd1;
  localparam logic [1:0] OP_STEP    = 2'd2;
  localparam logic [1:0] OP_CPU_RST = 2'd3;

  localparam logic [7:0]       RST_INIT = 8'(RST_CYCLES);
  localparam logic [CYC_W-1:0] CYC_MAX  = {CYC_W{1'b1}};

  typedef enum logic [1:0] {
    S_RSTSEQ = 2'd0,
    S_IDLE   = 2'd1,
    S_RUN    = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [7:0]       rst_cnt_reg, rst_cnt_next;
  logic [CNT_W-1:0] remaining_reg, remaining_next;
  logic             first_reg, first_next;
  logic             enable_reg;
  logic             cpu_rst_reg;
  logic [CYC_W-1:0] cycle_reg;
  logic             bp_hit_reg;
  logic             bp_fire;
  logic             clr_count;
  logic             accept;
  logic             bp_match;

  assign cmd_ready   = (state_reg != S_RSTSEQ);
  assign busy        = (state_reg != S_IDLE);
  assign enable      = enable_reg;
  assign cpu_rst     = cpu_rst_reg;
  assign cycle_count = cycle_reg;
  assign accept      = cmd_valid && cmd_ready;

`ifdef PIPE_RUN_CTRL_BREAKPOINT_EN
  // A breakpoint only counts on an enabled cycle that is not the first one
  // after resuming from IDLE, so a resume at the breakpoint PC moves forward.
  assign bp_match = enable_reg && bp_en && (pc_in == bp_addr) && !first_reg;
  assign bp_hit   = bp_hit_reg;
`else
  logic pc_unused;
  assign bp_match  = 1'b0;
  assign pc_unused = ^{pc_in, bp_hit_reg, first_reg};
`endif

  // Next-state logic; the if-chain order encodes command priority.
  always_comb begin
    state_next     = state_reg;
    rst_cnt_next   = rst_cnt_reg;
    remaining_next = remaining_reg;
    first_next     = 1'b0;
    bp_fire        = 1'b0;
    clr_count      = 1'b0;
    case (state_reg)
      S_RSTSEQ: begin
        if (rst_cnt_reg <= 8'd1) begin
          state_next   = S_IDLE;
          rst_cnt_next = 8'd0;
        end else begin
          rst_cnt_next = rst_cnt_reg - 8'd1;
        end
      end
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_CPU_RST: begin
              state_next   = S_RSTSEQ;
              rst_cnt_next = RST_INIT;
              clr_count    = 1'b1;
            end
            OP_RUN: begin
              state_next = S_RUN;
              first_next = 1'b1;
            end
            OP_STEP: begin
              if (cmd_count != '0) begin
                state_next     = S_STEP;
                remaining_next = cmd_count;
                first_next     = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      S_RUN, S_STEP: begin
        if (accept && cmd_op == OP_CPU_RST) begin
          state_next     = S_RSTSEQ;
          rst_cnt_next   = RST_INIT;
          remaining_next = '0;
          clr_count      = 1'b1;
        end else if (accept && cmd_op == OP_HALT) begin
          state_next     = S_IDLE;
          remaining_next = '0;
        end else if (bp_match) begin
          state_next     = S_IDLE;
          remaining_next = '0;
          bp_fire        = 1'b1;
        end else if (state_reg == S_STEP && remaining_reg <= CNT_W'(1)) begin
          state_next     = S_IDLE;
          remaining_next = '0;
        end else if (accept && cmd_op == OP_RUN) begin
          state_next     = S_RUN;
          remaining_next = '0;
        end else if (state_reg == S_STEP) begin
          remaining_next = remaining_reg - CNT_W'(1);
        end
      end
      default: begin
        state_next   = S_RSTSEQ;
        rst_cnt_next = RST_INIT;
      end
    endcase
  end

  // State, registered outputs and the saturating enabled-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= S_RSTSEQ;
      rst_cnt_reg   <= RST_INIT;
      remaining_reg <= '0;
      first_reg     <= 1'b0;
      enable_reg    <= 1'b0;
      cpu_rst_reg   <= 1'b1;
      cycle_reg     <= '0;
      bp_hit_reg    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      rst_cnt_reg   <= rst_cnt_next;
      remaining_reg <= remaining_next;
      first_reg     <= first_next;
      enable_reg    <= (state_next == S_RUN) || (state_next == S_STEP);
      cpu_rst_reg   <= (state_next == S_RSTSEQ);
      bp_hit_reg    <= bp_fire;
      if (clr_count) begin
        cycle_reg <= '0;
      end else if (enable_reg && cycle_reg != CYC_MAX) begin
        cycle_reg <= cycle_reg + CYC_W'(1);
      end
    end
  end

endmodule

// File: doc/pipeline_run_ctrl.md
Name: pipeline_run_ctrl

Overview:
- Run-control unit for the pipelined CPU. Generates the core's `enable` and `cpu_rst` from a command interface: free-run, halt, step N cycles, or a timed CPU reset.
- Replaces hand-toggled enable/reset sequencing with a synthesizable controller.
- Sits between the debug/host command source and the pipeline top's enable/reset inputs.
- Also counts enabled cycles.

Parameters:
- CNT_W, 16: width of the step count field.
- PC_W, 32: width of the observed program counter.
- CYC_W, 32: width of the enabled-cycle counter.
- RST_CYCLES, 2: number of cycles `cpu_rst` is held during a reset sequence; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  2  0=HALT, 1=RUN, 2=STEP, 3=CPU_RST.
- cmd_count  in  CNT_W  step count, used only by STEP.
- pc_in  in  PC_W  current PC from the pipeline fetch stage.
- enable  out  1  pipeline enable, registered.
- cpu_rst  out  1  pipeline reset, registered, active-high.
- busy  out  1  state != IDLE.
- cycle_count  out  CYC_W  number of cycles with enable=1; saturating.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- States: RSTSEQ, IDLE, RUN, STEP.
- On rst:
  - state=RSTSEQ, rst_cnt=RST_CYCLES.
  - enable=0, cpu_rst=1, busy=1, cycle_count=0, remaining=0, cmd_ready=0.
- RSTSEQ:
  - cpu_rst=1, enable=0.
  - rst_cnt decrements each cycle; on reaching 0, go to IDLE, with cpu_rst=0 from that cycle.
  - cmd_ready=0 throughout.
- cmd_ready=1 in IDLE, RUN and STEP. Every command presented is consumed in one cycle.
- IDLE (enable=0):
  - RUN -> RUN.
  - STEP with count N>0 -> STEP, remaining=N.
  - STEP with count 0 -> stay IDLE (accepted, no effect).
  - HALT -> stay IDLE.
  - CPU_RST -> RSTSEQ; cycle_count cleared.
- Latency: a command accepted at edge k changes enable from cycle k+1.
- RUN: enable=1 every cycle until HALT or CPU_RST.
- STEP:
  - enable=1 for exactly N cycles.
  - remaining decrements each enabled cycle; when remaining==1 the next state is IDLE.
  - RUN accepted in STEP converts to RUN.
  - STEP accepted in RUN or STEP is dropped.
- Priority on the same edge: rst > CPU_RST > HALT > breakpoint > step terminal > RUN/STEP.
- cycle_count:
  - +1 on each cycle where enable=1.
  - Saturates at 2^CYC_W-1.
  - Cleared on rst and on entry to RSTSEQ.
- Mid-operation:
  - CPU_RST in RUN/STEP drops enable the next cycle and aborts the remaining step count (set to 0).
  - rst at any time overrides everything.

Optional Feature:
- Macro: PIPE_RUN_CTRL_BREAKPOINT_EN.
- When defined, adds these ports:
  - bp_en  in  1
  - bp_addr  in  PC_W
  - bp_hit  out  1  (reset 0)
- Breakpoint rule:
  - In RUN or STEP, if enable=1 && bp_en && pc_in==bp_addr, the next state is IDLE.
  - bp_hit pulses 1 for one cycle at the halt.
  - The breakpoint is ignored on the first enabled cycle after entering RUN/STEP from IDLE, so resuming at a breakpoint address makes progress.
- When undefined: ports absent; behaviour as above with no breakpoint halts.

Test Plan:
- Reset release: rst=1 for 3 cycles, then 0 with RST_CYCLES=2 -> cpu_rst=1 for 2 cycles after release; then IDLE with enable=0, busy=0, cmd_ready=1, cycle_count=0.
- Step 5: STEP count=5 accepted at edge k -> enable=1 for cycles k+1..k+5, 0 at k+6; cycle_count=5; busy falls at k+6. Then STEP count=0 -> enable stays 0, cycle_count stays 5.
- Run/halt: RUN, then HALT 10 cycles later -> enable high exactly 10 cycles; cycle_count=10. A second HALT while IDLE has no effect.
- CPU reset mid-step: STEP count=100, CPU_RST after 7 enabled cycles -> enable=0 next cycle; cpu_rst=1 for RST_CYCLES; cycle_count=0; final state IDLE; remaining step count discarded.
- Saturation: CYC_W=4, RUN for 20 cycles -> cycle_count stops at 15.
- Breakpoint (macro defined): bp_en=1, bp_addr=0x20, pc_in sweeps 0x0,0x4,...,0x20 in RUN -> bp_hit=1 one cycle, enable=0 after 0x20. Issuing RUN again with pc_in=0x20 -> no immediate halt; pipeline advances.
